// File: rtl/quad_gray_decoder_pkg.sv
// Shared Gray-code definitions for the quadrature decoder and encoder FSMs.
// Holds the state encodings, step functions and step classifier.
`timescale 1ps/1ps
package quad_gray_decoder_pkg;

    localparam logic [1:0] G0 = 2'b00;
    localparam logic [1:0] G1 = 2'b01;
    localparam logic [1:0] G2 = 2'b11;
    localparam logic [1:0] G3 = 2'b10;

    typedef enum logic [1:0] {
        CLS_HOLD,
        CLS_FWD,
        CLS_REV,
        CLS_ERR
    } step_cls_e;

    function automatic logic [1:0] gray_fwd(input logic [1:0] prev);
        logic [1:0] nxt;
        case (prev)
            G0:      nxt = G1;
            G1:      nxt = G2;
            G2:      nxt = G3;
            default: nxt = G0;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] gray_rev(input logic [1:0] prev);
        logic [1:0] nxt;
        case (prev)
            G0:      nxt = G3;
            G3:      nxt = G2;
            G2:      nxt = G1;
            default: nxt = G0;
        endcase
        return nxt;
    endfunction

    // Any change that is neither neighbour flips both bits.
    function automatic step_cls_e gray_classify(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        step_cls_e cls;
        if (cur == prev) begin
            cls = CLS_HOLD;
        end else if (cur == gray_fwd(prev)) begin
            cls = CLS_FWD;
        end else if (cur == gray_rev(prev)) begin
            cls = CLS_REV;
        end else begin
            cls = CLS_ERR;
        end
        return cls;
    endfunction

endpackage

// File: rtl/quad_gray_decoder_sync_ff.sv
// Single-bit multi-stage synchronizer with asynchronous active-low reset.
`timescale 1ps/1ps
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quad_gray_decoder.sv
// Quadrature / Gray-code receiver: synchronizes {a_in,b_in}, decodes steps,
// tracks direction, sticky illegal-jump flag and a wrapping position.
`timescale 1ps/1ps
module quad_gray_decoder
    import quad_gray_decoder_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic             step_up,
    output logic             step_dn,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] pos
);

    logic             a_s;
    logic             b_s;
    logic [1:0]       cur;
    step_cls_e        cls;

    logic [1:0]       prev_q, prev_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pos_q, pos_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .rstn (rstn),
        .d    (a_in),
        .q    (a_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk  (clk),
        .rstn (rstn),
        .d    (b_in),
        .q    (b_s)
    );

    assign cur = {a_s, b_s};

    always_comb begin
        cls = gray_classify(prev_q, cur);
    end

    // prev always follows cur so a bad jump resyncs on the next sample.
    always_comb begin
        prev_d    = cur;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q;
        pos_d     = pos_q;
        case (cls)
            CLS_FWD: begin
                step_up_d = 1'b1;
                dir_d     = 1'b1;
                pos_d     = pos_q + CNT_W'(1);
            end
            CLS_REV: begin
                step_dn_d = 1'b1;
                dir_d     = 1'b0;
                pos_d     = pos_q - CNT_W'(1);
            end
            CLS_ERR: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
        // Clear overrides position and error, but not pulses or direction.
        if (clr) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q    <= G0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
            pos_q     <= '0;
        end else begin
            prev_q    <= prev_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
        end
    end

    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign pos     = pos_q;

endmodule

// File: tb/tb_quad_gray_decoder.sv
// Directed self-checking bench for quad_gray_decoder.
`timescale 1ps/1ps
module tb_quad_gray_decoder;

    logic       clk;
    logic       rstn;
    logic       a_in;
    logic       b_in;
    logic       clr;
    logic       step_up;
    logic       step_dn;
    logic       dir;
    logic       err;
    logic [7:0] pos;

    int errors;
    int checks;
    int up_cnt;
    int dn_cnt;
    int both_cnt;

    quad_gray_decoder #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .a_in    (a_in),
        .b_in    (b_in),
        .clr     (clr),
        .step_up (step_up),
        .step_dn (step_dn),
        .dir     (dir),
        .err     (err),
        .pos     (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_up) up_cnt++;
        if (step_dn) dn_cnt++;
        if (step_up && step_dn) both_cnt++;
    end

    task automatic clear_counts();
        @(posedge clk);
        #1;
        up_cnt = 0;
        dn_cnt = 0;
    endtask

    task automatic drive(input logic [1:0] v, input int hold);
        @(negedge clk);
        {a_in, b_in} = v;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic flush();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        clr  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (step_up !== 1'b0 || step_dn !== 1'b0 || dir !== 1'b1 ||
            err !== 1'b0 || pos !== 8'd0) begin
            errors++;
            $display("FAIL reset: up=%b dn=%b dir=%b err=%b pos=%0d want 0 0 1 0 0",
                     step_up, step_dn, dir, err, pos);
        end
        rstn = 1'b1;
        clear_counts();
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        clear_counts();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) drive(seq[i], 3);
        end
        flush();
        checks++;
        if (up_cnt != 8 || dn_cnt != 0) begin
            errors++;
            $display("FAIL fwd_pulses: up=%0d dn=%0d want 8 0", up_cnt, dn_cnt);
        end
        checks++;
        if (pos !== 8'd8 || dir !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_state: pos=%0d dir=%b err=%b want 8 1 0", pos, dir, err);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [4];
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        clear_counts();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) drive(seq[i], 3);
        end
        flush();
        checks++;
        if (dn_cnt != 12 || up_cnt != 0) begin
            errors++;
            $display("FAIL rev_pulses: dn=%0d up=%0d want 12 0", dn_cnt, up_cnt);
        end
        checks++;
        if (pos !== 8'd252 || dir !== 1'b0) begin
            errors++;
            $display("FAIL rev_state: pos=%0d dir=%b want 252 0", pos, dir);
        end
    endtask

    task automatic test_illegal_jump();
        clear_counts();
        @(negedge clk);
        {a_in, b_in} = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: err=%b want 0 after 2 edges", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b want 1 after 3 edges", err);
        end
        flush();
        checks++;
        if (up_cnt != 0 || dn_cnt != 0 || pos !== 8'd252) begin
            errors++;
            $display("FAIL err_hold: up=%0d dn=%0d pos=%0d want 0 0 252",
                     up_cnt, dn_cnt, pos);
        end
        clear_counts();
        drive(2'b10, 1);
        flush();
        checks++;
        if (up_cnt != 1 || pos !== 8'd253 || dir !== 1'b1) begin
            errors++;
            $display("FAIL resync: up=%0d pos=%0d dir=%b want 1 253 1",
                     up_cnt, pos, dir);
        end
    endtask

    task automatic test_wrap_and_clr();
        drive(2'b00, 3);
        drive(2'b01, 3);
        flush();
        checks++;
        if (pos !== 8'd255) begin
            errors++;
            $display("FAIL pre_wrap: pos=%0d want 255", pos);
        end
        drive(2'b11, 1);
        flush();
        checks++;
        if (pos !== 8'd0) begin
            errors++;
            $display("FAIL wrap_up: pos=%0d want 0", pos);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b want 1", err);
        end
        // Step 11->10 lands on the third edge; clr is held only for that edge.
        @(negedge clk);
        {a_in, b_in} = 2'b10;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (step_up !== 1'b1 || pos !== 8'd0 || err !== 1'b0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL clr_step: up=%b pos=%0d err=%b dir=%b want 1 0 0 1",
                     step_up, pos, err, dir);
        end
        flush();
    endtask

    task automatic test_latency();
        @(posedge clk);
        #9;
        a_in = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (step_up !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: up=%b want 0 after edge k+1", step_up);
        end
        @(posedge clk);
        #1;
        checks++;
        if (step_up !== 1'b1 || pos !== 8'd1) begin
            errors++;
            $display("FAIL lat_pulse: up=%b pos=%0d want 1 1 after edge k+2",
                     step_up, pos);
        end
        @(posedge clk);
        #1;
        checks++;
        if (step_up !== 1'b0) begin
            errors++;
            $display("FAIL lat_deassert: up=%b want 0", step_up);
        end
    endtask

    task automatic test_reset_mid();
        // Reverse step 00->10 so dir is 0 before the async reset hits.
        drive(2'b10, 3);
        flush();
        checks++;
        if (dir !== 1'b0 || pos !== 8'd0) begin
            errors++;
            $display("FAIL pre_rst: dir=%b pos=%0d want 0 0", dir, pos);
        end
        drive(2'b00, 3);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (step_up !== 1'b0 || step_dn !== 1'b0 || dir !== 1'b1 ||
            err !== 1'b0 || pos !== 8'd0) begin
            errors++;
            $display("FAIL async_rst: up=%b dn=%b dir=%b err=%b pos=%0d want 0 0 1 0 0",
                     step_up, step_dn, dir, err, pos);
        end
        {a_in, b_in} = 2'b01;
        @(negedge clk);
        clear_counts();
        @(negedge clk);
        rstn = 1'b1;
        flush();
        checks++;
        if (up_cnt != 1 || pos !== 8'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_step: up=%0d pos=%0d err=%b want 1 1 0",
                     up_cnt, pos, err);
        end
        @(negedge clk);
        rstn = 1'b0;
        {a_in, b_in} = 2'b11;
        @(negedge clk);
        clear_counts();
        @(negedge clk);
        rstn = 1'b1;
        flush();
        checks++;
        if (err !== 1'b1 || pos !== 8'd0 || up_cnt != 0 || dn_cnt != 0) begin
            errors++;
            $display("FAIL park11: err=%b pos=%0d up=%0d dn=%0d want 1 0 0 0",
                     err, pos, up_cnt, dn_cnt);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL park11_clr: err=%b want 0", err);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        up_cnt   = 0;
        dn_cnt   = 0;
        both_cnt = 0;
        test_reset();
        test_forward();
        test_reverse();
        test_illegal_jump();
        test_wrap_and_clr();
        test_latency();
        test_reset_mid();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL both_pulses: count=%0d want 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
